// File: rtl/motor_mmio_multi.sv
// APB3 register block commanding NUM_CH stepper channels: signed step commands,
// per-channel load strobes, armed completion detection and a level interrupt.
module motor_mmio_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    PCLK,
  input  logic                    PRESERN,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [NUM_CH*CNT_W-1:0] cnt_in,
  input  logic [NUM_CH-1:0]       dir_in,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic [NUM_CH-1:0]       dir_out,
  output logic [NUM_CH-1:0]       load,
  output logic                    FABINT
);

  localparam logic [3:0] W_STATUS = 4'd8;
  localparam logic [3:0] W_IRQ_EN = 4'd9;
  localparam logic [3:0] W_BUSY   = 4'd10;

  logic [3:0]        w;
  logic              acc, wr, cmd_hit, mapped;
  logic [NUM_CH-1:0] done, armed, irq_en, last_zero, zero, evt;
  logic [CNT_W-1:0]  wmag;
  logic              unused_bits;

  // Magnitude of a two's-complement count; the most-negative value maps to 2^(CNT_W-1).
  function automatic logic [CNT_W-1:0] cmd_mag(input logic [CNT_W-1:0] v);
    logic signed [CNT_W-1:0] s;
    s = signed'(v);
    return s[CNT_W-1] ? $unsigned(-s) : v;
  endfunction

  function automatic logic [31:0] cmd_readback(input logic [CNT_W-1:0] c, input logic fwd);
    logic signed [32:0] v;
    v = signed'(33'(c));
    if (!fwd) v = -v;
    return v[31:0];
  endfunction

  assign w           = PADDR[5:2];
  assign acc         = PSEL & PENABLE;
  assign wr          = acc & PWRITE;
  assign cmd_hit     = ({28'd0, w} < 32'(NUM_CH));
  assign mapped      = cmd_hit | (w == W_STATUS) | (w == W_IRQ_EN) | (w == W_BUSY);
  assign wmag        = cmd_mag(PWDATA[CNT_W-1:0]);
  assign PREADY      = 1'b1;
  assign PSLVERR     = acc & ~mapped;
  assign FABINT      = |(done & irq_en);
  assign unused_bits = ^{PADDR[31:6], PADDR[1:0], PWDATA};

  always_comb begin
    zero = '0;
    evt  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      zero[k] = (cnt_in[k*CNT_W +: CNT_W] == '0);
      evt[k]  = armed[k] & zero[k] & ~last_zero[k];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (acc) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w == 4'(k)) PRDATA = cmd_readback(cnt_in[k*CNT_W +: CNT_W], dir_in[k]);
      end
      case (w)
        W_STATUS: PRDATA = 32'(done);
        W_IRQ_EN: PRDATA = 32'(irq_en);
        W_BUSY:   PRDATA = 32'(armed);
        default:  ;
      endcase
    end
  end

  // A command write outranks a same-edge completion; a completion outranks W1C.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cnt_out   <= '0;
      dir_out   <= '0;
      load      <= '0;
      done      <= '0;
      armed     <= '0;
      irq_en    <= '0;
      last_zero <= '1;
    end else begin
      last_zero <= zero;
      load      <= '0;
      if (wr && w == W_IRQ_EN) irq_en <= PWDATA[NUM_CH-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr && w == 4'(k)) begin
          cnt_out[k*CNT_W +: CNT_W] <= wmag;
          dir_out[k]                <= ~PWDATA[CNT_W-1];
          load[k]                   <= (wmag != '0);
          armed[k]                  <= (wmag != '0);
          done[k]                   <= (wmag == '0);
        end else if (evt[k]) begin
          done[k]  <= 1'b1;
          armed[k] <= 1'b0;
        end else if (wr && w == W_STATUS && PWDATA[k]) begin
          done[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_mmio_multi.sv
// Bench for motor_mmio_multi: directed APB sequences plus randomized traffic,
// compared every cycle against a spec-level model of the register block.
module tb_motor_mmio_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;

  logic                    PCLK, PRESERN, PSEL, PENABLE, PWRITE;
  logic [31:0]             PADDR, PWDATA, PRDATA;
  logic                    PREADY, PSLVERR, FABINT;
  logic [NUM_CH*CNT_W-1:0] cnt_in, cnt_out;
  logic [NUM_CH-1:0]       dir_in, dir_out, load;

  int checks = 0;
  int failures = 0;

  logic [NUM_CH-1:0] m_done, m_armed, m_irq, m_lz, m_load, m_dir;
  logic [CNT_W-1:0]  m_cnt [NUM_CH];

  motor_mmio_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cnt_in(cnt_in), .dir_in(dir_in), .cnt_out(cnt_out), .dir_out(dir_out),
    .load(load), .FABINT(FABINT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_done = '0; m_armed = '0; m_irq = '0; m_lz = '1; m_load = '0; m_dir = '0;
    for (int k = 0; k < NUM_CH; k++) m_cnt[k] = '0;
  endtask

  function automatic logic m_err(input int w);
    return !((w < NUM_CH) || w == 8 || w == 9 || w == 10);
  endfunction

  function automatic logic [31:0] m_read(input int w);
    longint c;
    if (w < NUM_CH) begin
      c = longint'(cnt_in[w*CNT_W +: CNT_W]);
      if (!dir_in[w]) c = -c;
      return c[31:0];
    end
    case (w)
      8:  return 32'(m_done);
      9:  return 32'(m_irq);
      10: return 32'(m_armed);
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model over one clock edge, then compare registered outputs.
  task automatic tick();
    logic wr, z, evt;
    int w;
    longint v, mag;
    logic [NUM_CH-1:0] nd, na, ni, nld, nlz, ndir;
    logic [CNT_W-1:0] nc [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] ecnt;
    wr = PSEL && PENABLE && PWRITE;
    w = int'(PADDR[5:2]);
    nd = m_done; na = m_armed; ni = m_irq; nld = '0; ndir = m_dir; nlz = '0;
    nc = m_cnt;
    for (int k = 0; k < NUM_CH; k++) begin
      z = (cnt_in[k*CNT_W +: CNT_W] == 0);
      evt = m_armed[k] && z && !m_lz[k];
      if (evt) begin nd[k] = 1'b1; na[k] = 1'b0; end
      else if (wr && w == 8 && PWDATA[k]) nd[k] = 1'b0;
      if (wr && w == k) begin
        v = longint'($signed(PWDATA));
        mag = (v < 0) ? -v : v;
        nc[k] = mag[CNT_W-1:0];
        ndir[k] = (v >= 0);
        nld[k] = (mag != 0);
        na[k] = (mag != 0);
        nd[k] = (mag == 0);
      end
      nlz[k] = z;
    end
    if (wr && w == 9) ni = PWDATA[NUM_CH-1:0];
    @(posedge PCLK);
    #1;
    m_done = nd; m_armed = na; m_irq = ni; m_load = nld; m_dir = ndir; m_lz = nlz;
    m_cnt = nc;
    for (int k = 0; k < NUM_CH; k++) ecnt[k*CNT_W +: CNT_W] = m_cnt[k];
    chk("load", 64'(load), 64'(m_load));
    chk("dir_out", 64'(dir_out), 64'(m_dir));
    chk("cnt_out", 64'(cnt_out), 64'(ecnt));
    chk("fabint", 64'(FABINT), 64'(|(m_done & m_irq)));
  endtask

  task automatic apb_write(input int w, input logic [31:0] d, input int zch = -1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'(w) << 2; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    if (zch >= 0) cnt_in[zch*CNT_W +: CNT_W] = '0;
    #3;
    chk("wr_pslverr", 64'(PSLVERR), 64'(m_err(w)));
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int w, input logic [31:0] exp, input string tag,
                          input bit use_model = 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'(w) << 2;
    #3;
    chk("setup_rdata", 64'(PRDATA), 64'd0);
    tick();
    PENABLE = 1'b1;
    #3;
    if (use_model) exp = m_read(w);
    chk({tag, "_data"}, 64'(PRDATA), 64'(exp));
    chk({tag, "_err"}, 64'(PSLVERR), 64'(m_err(w)));
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [31:0] rand_cmd();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; cnt_in = '0; dir_in = '0;
    m_reset();
    repeat (3) begin
      @(posedge PCLK); #1;
      chk("rst_load", 64'(load), 64'd0);
      chk("rst_fabint", 64'(FABINT), 64'd0);
    end
    #2 PRESERN = 1'b1;

    for (int w = 0; w < 11; w++)
      if (!m_err(w)) apb_read(w, 32'd0, "rst_read");

    // -100 on channel 1
    apb_write(1, 32'hFFFF_FF9C);
    chk("cmd1_cnt", 64'(cnt_out[CNT_W +: CNT_W]), 64'd100);
    chk("cmd1_dir", 64'(dir_out[1]), 64'd0);
    chk("cmd1_load", 64'(load), 64'h2);
    tick();
    chk("cmd1_load_end", 64'(load), 64'h0);
    apb_read(10, 32'h2, "busy_ch1");
    cnt_in[CNT_W +: CNT_W] = 32'd40;
    dir_in[1] = 1'b0;
    apb_read(1, 32'hFFFF_FFD8, "cmd1_readback");

    // channel 0 runs 5 steps to completion with interrupts enabled
    apb_write(9, 32'h3);
    apb_write(0, 32'd5);
    cnt_in[0 +: CNT_W] = 32'd5;
    tick();
    for (int v = 4; v >= 0; v--) begin
      cnt_in[0 +: CNT_W] = 32'(v);
      tick();
    end
    chk("fabint_done0", 64'(FABINT), 64'd1);
    apb_read(8, 32'h1, "status_done0");
    apb_read(10, 32'h2, "busy_after0");
    apb_write(8, 32'h1);
    chk("fabint_w1c", 64'(FABINT), 64'd0);

    // zero command completes immediately without a load pulse
    apb_write(0, 32'd0);
    chk("zero_no_load", 64'(load), 64'd0);
    apb_read(8, 32'h1, "status_zero_cmd");
    apb_write(8, 32'h1);
    repeat (4) tick();
    apb_read(8, 32'h0, "status_unarmed_zero");

    // W1C collides with channel-1 completion: completion wins
    apb_write(8, 32'h2, 1);
    apb_read(8, 32'h2, "status_set_wins");
    chk("fabint_ch1", 64'(FABINT), 64'd1);

    // command write collides with completion: write wins
    apb_write(1, 32'd7);
    cnt_in[CNT_W +: CNT_W] = 32'd7;
    repeat (2) tick();
    apb_write(1, 32'd9, 1);
    apb_read(8, 32'h0, "status_write_wins");
    apb_read(10, 32'h2, "busy_write_wins");

    // most-negative command
    apb_write(0, 32'h8000_0000);
    chk("mostneg_cnt", 64'(cnt_out[0 +: CNT_W]), 64'h8000_0000);

    // unmapped accesses
    apb_read(5, 32'd0, "unmapped_rd5");
    apb_write(12, 32'hFFFF_FFFF);
    apb_write(3, 32'h0000_0011);
    apb_read(9, 32'd0, "irq_after_unmapped", 1'b1);
    apb_read(8, 32'd0, "status_after_unmapped", 1'b1);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4 && cnt_in[k*CNT_W +: CNT_W] != 0)
          cnt_in[k*CNT_W +: CNT_W] = cnt_in[k*CNT_W +: CNT_W] - 1;
        else if (r == 9) cnt_in[k*CNT_W +: CNT_W] = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) dir_in[k] = 1'($urandom);
      end
      case ($urandom_range(0, 5))
        0, 1: apb_write($urandom_range(0, NUM_CH - 1), rand_cmd());
        2: apb_write(8, $urandom);
        3: apb_write(9, $urandom);
        4: apb_read($urandom_range(0, 15), 32'd0, "rnd_read", 1'b1);
        default: tick();
      endcase
    end

    // asynchronous reset in the middle of a command
    apb_write(9, 32'h3);
    apb_write(1, 32'hFFFF_FF9C);
    apb_write(0, 32'd0);
    chk("pre_rst_fabint", 64'(FABINT), 64'd1);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'd0; PWDATA = 32'd3;
    tick();
    PENABLE = 1'b1;
    #2 PRESERN = 1'b0;
    #1;
    chk("arst_cnt_out", 64'(cnt_out), 64'd0);
    chk("arst_dir_out", 64'(dir_out), 64'd0);
    chk("arst_load", 64'(load), 64'd0);
    chk("arst_fabint", 64'(FABINT), 64'd0);
    m_reset();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    chk("arst_hold_load", 64'(load), 64'd0);
    #2 PRESERN = 1'b1;
    for (int w = 8; w < 11; w++) apb_read(w, 32'd0, "post_rst_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
